// File: rtl/ssd_pkg.sv
// Shared definitions for the multiplexed seven-segment ALU display:
// opcode encoding and the hex-to-segment lookup table ({a,b,c,d,e,f,g}, active-high).
package ssd_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_OR  = 2'd1,
        OP_SUB = 2'd2,
        OP_XOR = 2'd3
    } opcode_e;

    // Entry k holds the segment pattern for hex digit k (entry 0 is the rightmost field).
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'b1000111,  // F
        7'b1001111,  // E
        7'b0111101,  // d
        7'b1001110,  // C
        7'b0011111,  // b
        7'b1110111,  // A
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to seven-segment decoder built on the package table.
module hex_to_seg7
    import ssd_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG7_TABLE[hex];

endmodule

// File: rtl/ssd_mux_alu.sv
// Time-multiplexed seven-segment display driver with a small operand ALU.
// A load strobe captures the ALU result; the result is scanned out in hex,
// one digit per PRESCALE clock cycles, all outputs registered.
// Optional build macro: SSD_MUX_LEADING_ZERO_BLANK_EN blanks leading zero
// digits (digit 0 is always shown, the anode stays active while blanked).
module ssd_mux_alu
    import ssd_pkg::*;
#(
    parameter int N        = 8,
    parameter int DIGITS   = 3,
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      A,
    input  logic [N-1:0]      B,
    input  logic [1:0]        Opcode,
    input  logic              Enable,
    input  logic              load,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              frame_done
);

    localparam int PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DISP_W = DIGITS * 4;

    logic [N:0]               result_q;
    logic [N:0]               alu_res;
    logic [PW-1:0]            pre_q;
    logic [DW-1:0]            dig_q;
    logic                     wrap_q;

    logic [DIGITS-1:0][3:0]   digits;
    logic [3:0]               cur_nib;
    logic [6:0]               dec_seg;
    logic [6:0]               seg_next;
    logic [DIGITS-1:0]        an_next;
    logic                     blank;
    logic                     pre_last;
    logic                     dig_last;

    // ALU: ADD keeps the carry and SUB the borrow in bit N; logic ops zero-extend.
    always_comb begin
        alu_res = '0;
        case (opcode_e'(Opcode))
            OP_ADD:  alu_res = {1'b0, A} + {1'b0, B};
            OP_OR:   alu_res = {1'b0, A | B};
            OP_SUB:  alu_res = {1'b0, A} - {1'b0, B};
            OP_XOR:  alu_res = {1'b0, A ^ B};
            default: alu_res = '0;
        endcase
    end

    // Result is zero-padded (or truncated) to a whole number of hex digits.
    assign digits  = DISP_W'(result_q);
    assign cur_nib = digits[dig_q];

    hex_to_seg7 u_dec (
        .hex (cur_nib),
        .seg (dec_seg)
    );

`ifdef SSD_MUX_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] upper_zero;

    // upper_zero[i] is set when digit i and every digit above it are zero.
    always_comb begin
        upper_zero             = '0;
        upper_zero[DIGITS-1]   = (digits[DIGITS-1] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (digits[i] == 4'd0);
        end
    end

    assign blank = (dig_q != '0) && upper_zero[dig_q];
`else
    assign blank = 1'b0;
`endif

    assign seg_next = blank ? 7'd0 : dec_seg;
    assign an_next  = DIGITS'(1) << dig_q;
    assign pre_last = (pre_q == PW'(PRESCALE - 1));
    assign dig_last = (dig_q == DW'(DIGITS - 1));

    // Result register: load is accepted whether or not the display is enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
        end else if (load) begin
            result_q <= alu_res;
        end
    end

    // Scan counters and registered outputs; outputs reflect the pre-edge digit,
    // and frame_done follows the digit wrap by one edge so it lines up with digit 0.
    always_ff @(posedge clk) begin
        if (!rst_n || !Enable) begin
            pre_q      <= '0;
            dig_q      <= '0;
            wrap_q     <= 1'b0;
            seg        <= '0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            an         <= an_next;
            frame_done <= wrap_q;
            wrap_q     <= pre_last && dig_last;
            if (pre_last) begin
                pre_q <= '0;
                dig_q <= dig_last ? '0 : dig_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssd_mux_alu.sv
// Directed bench for ssd_mux_alu (N=8, DIGITS=3, PRESCALE=2): a vector table of
// ALU operations with expected per-digit segments, plus reset/enable/load sequences.
module tb_ssd_mux_alu;

    localparam int N        = 8;
    localparam int DIGITS   = 3;
    localparam int PRESCALE = 2;

`ifdef SSD_MUX_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] Z0 = 7'b0000000;
`else
    localparam logic [6:0] Z0 = 7'b1111110;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      A;
    logic [N-1:0]      B;
    logic [1:0]        Opcode;
    logic              Enable;
    logic              load;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;
    logic              frame_done;

    int checks   = 0;
    int failures = 0;

    ssd_mux_alu #(.N(N), .DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .B          (B),
        .Opcode     (Opcode),
        .Enable     (Enable),
        .load       (load),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [6:0] s0;
        logic [6:0] s1;
        logic [6:0] s2;
        string      name;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        A = a; B = b; Opcode = op; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [6:0] got [3];
        int fd_cnt;
        int misaligned;
        got[0] = 7'h7F; got[1] = 7'h7F; got[2] = 7'h7F;
        fd_cnt = 0; misaligned = 0;
        do_load(v.a, v.b, v.op);
        for (int c = 0; c < 2 * DIGITS * PRESCALE; c++) begin
            tick();
            case (an)
                3'b001: got[0] = seg;
                3'b010: got[1] = seg;
                3'b100: got[2] = seg;
                default: misaligned++;
            endcase
            if (frame_done) begin
                fd_cnt++;
                if (an != 3'b001) misaligned++;
            end
        end
        chk({v.name, "_d0"}, 32'(got[0]), 32'(v.s0));
        chk({v.name, "_d1"}, 32'(got[1]), 32'(v.s1));
        chk({v.name, "_d2"}, 32'(got[2]), 32'(v.s2));
        chk({v.name, "_frame_cnt"}, 32'(fd_cnt), 32'd2);
        chk({v.name, "_align"}, 32'(misaligned), 32'd0);
    endtask

    // Waits for the first sample of a new dwell on the given anode; bounded.
    task automatic wait_an_start(input logic [2:0] target, input string nm);
        logic [2:0] prev;
        bit found;
        prev = an; found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (an == target && prev != target) found = 1'b1;
            prev = an;
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "simulation timeout");
    end

    initial begin
        vecs[0] = '{8'hFF, 8'h01, 2'd0, 7'b1111110, 7'b1111110, 7'b0110000, "add_carry"};
        vecs[1] = '{8'h05, 8'h07, 2'd2, 7'b1001111, 7'b1000111, 7'b0110000, "sub_borrow"};
        vecs[2] = '{8'h0A, 8'h00, 2'd1, 7'b1110111, Z0,         Z0,         "or_lead0"};
        vecs[3] = '{8'h3C, 8'hA5, 2'd3, 7'b1111011, 7'b1111011, Z0,         "xor_99"};
        vecs[4] = '{8'h12, 8'h34, 2'd0, 7'b1011111, 7'b0110011, Z0,         "add_46"};
        vecs[5] = '{8'h00, 8'h01, 2'd2, 7'b1000111, 7'b1000111, 7'b0110000, "sub_1ff"};
        vecs[6] = '{8'hB0, 8'h0D, 2'd1, 7'b0111101, 7'b0011111, Z0,         "or_bd"};
        vecs[7] = '{8'h7C, 8'h0B, 2'd0, 7'b1110000, 7'b1111111, Z0,         "add_87"};

        // Reset held three cycles with load and enable active.
        rst_n = 1'b0; Enable = 1'b1; load = 1'b1;
        A = 8'hFF; B = 8'h01; Opcode = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_seg", 32'(seg), 32'd0);
            chk("rst_an", 32'(an), 32'd0);
            chk("rst_fd", 32'(frame_done), 32'd0);
        end
        rst_n = 1'b1; load = 1'b0;
        tick();
        chk("post_rst_an", 32'(an), 32'b001);
        chk("post_rst_seg", 32'(seg), 32'(7'b1111110));
        chk("post_rst_fd", 32'(frame_done), 32'd0);
        tick();
        chk("post_rst_dwell_an", 32'(an), 32'b001);
        tick();
        chk("post_rst_d1_an", 32'(an), 32'b010);
        chk("post_rst_d1_seg", 32'(seg), 32'(Z0));

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Disable while digit 2 is being scanned, then re-enable.
        do_load(8'h05, 8'h07, 2'd2);
        wait_an_start(3'b100, "wait_d2");
        Enable = 1'b0;
        tick();
        chk("dis_an", 32'(an), 32'd0);
        chk("dis_seg", 32'(seg), 32'd0);
        chk("dis_fd", 32'(frame_done), 32'd0);
        tick();
        chk("dis_hold_an", 32'(an), 32'd0);
        Enable = 1'b1;
        tick();
        chk("reen_an", 32'(an), 32'b001);
        chk("reen_seg", 32'(seg), 32'(7'b1001111));
        tick();
        chk("reen_dwell_an", 32'(an), 32'b001);
        tick();
        chk("reen_d1_an", 32'(an), 32'b010);
        chk("reen_d1_seg", 32'(seg), 32'(7'b1000111));

        // Reset in the middle of digit 1, then load on the wrap edge.
        wait_an_start(3'b010, "wait_d1");
        rst_n = 1'b0;
        tick();
        chk("mid_rst_an", 32'(an), 32'd0);
        chk("mid_rst_seg", 32'(seg), 32'd0);
        chk("mid_rst_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mid_rel_seg", 32'(seg), 32'(7'b1111110));
        tick(); tick(); tick();
        tick();
        chk("pre_wrap_an", 32'(an), 32'b100);
        A = 8'h0F; B = 8'h07; Opcode = 2'd3; load = 1'b1;
        tick();
        load = 1'b0;
        chk("load_edge_an", 32'(an), 32'b100);
        chk("load_edge_seg", 32'(seg), 32'(Z0));
        chk("load_edge_fd", 32'(frame_done), 32'd0);
        tick();
        chk("new_val_an", 32'(an), 32'b001);
        chk("new_val_seg", 32'(seg), 32'(7'b1111111));
        chk("new_val_fd", 32'(frame_done), 32'd1);
        tick();
        chk("fd_one_cycle", 32'(frame_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ssd_mux_alu.md
# ssd_mux_alu

Multi-digit, time-multiplexed seven-segment display driver with an operand ALU. Operands and opcode are captured into a result register on a load strobe. The result is shown in hex on DIGITS common-segment digits, one digit active at a time, scanned at a rate set by a prescaler. It sits between the operand/switch logic and the board's segment/anode pins, replacing the single-digit combinational display path.

## Interface
- N, 8: operand width in bits.
- DIGITS, 3: number of display digits. DIGITS*4 ≥ N+1 is required for a full display; result bits above DIGITS*4-1 are dropped.
- PRESCALE, 4: clock cycles each digit stays active (≥1).

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset: one clock, synchronous, active-low.
- A  in  N  operand A.
- B  in  N  operand B.
- Opcode  in  2  0 ADD, 1 OR, 2 SUB, 3 XOR.
- Enable  in  1  display enable; 0 blanks outputs and holds the scan at digit 0.
- load  in  1  capture ALU result of A, B, Opcode at this edge.
- seg  out  7  {a,b,c,d,e,f,g}, active-high.
- an  out  DIGITS  one-hot digit select, active-high; bit 0 is the least-significant hex digit.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0.

## Operation
- Registers:
  - result_q, N+1 bits.
  - pre_q: prescaler, 0..PRESCALE-1.
  - dig_q: digit index, 0..DIGITS-1.
  - seg, an, frame_done: all registered outputs.
- ALU, evaluated when load=1. Load is accepted regardless of Enable.
  - ADD: A+B, with carry in bit N.
  - SUB: A-B mod 2^(N+1), so a borrow sets bit N.
  - OR, XOR: zero-extended to N+1 bits.
- Digit value i is result_q[4i+3:4i]. Bits beyond N are zero-padded.
- Hex decode to {a..g}:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Scan state machine, while Enable=1:
  - pre_q counts up each cycle.
  - At PRESCALE-1, pre_q wraps to 0 and dig_q advances.
  - dig_q wraps DIGITS-1 → 0.
- Enable=0:
  - pre_q and dig_q are forced to 0.
  - seg=0, an=0, frame_done=0.
  - result_q is retained.

## Timing
- Reset (rst_n=0 at an edge): result_q=0, pre_q=0, dig_q=0, seg=0, an=0, frame_done=0. Reset overrides load and Enable, including mid-scan.
- Each edge with Enable=1:
  - seg <= decode(digit dig_q of result_q).
  - an <= 1<<dig_q.
  - Both use the pre-edge state, so outputs lag dig_q by one cycle.
- Load latency:
  - load sampled at edge k updates result_q at edge k.
  - seg shows the new value from edge k+1 onward, for whichever digit is then active.
  - Simultaneous load and digit advance: both take effect at the same edge.
- frame_done is asserted at the edge after dig_q wraps to 0, aligned with an=1 for digit 0. It lasts exactly one cycle.
- First edge after reset release with Enable=1: an=1, seg=1111110.
- Re-enable after Enable=0: the scan restarts at digit 0 with a full PRESCALE dwell.
- PRESCALE=1: the digit changes every cycle.
- DIGITS=1: frame_done pulses every PRESCALE cycles.

## Configuration
- SSD_MUX_LEADING_ZERO_BLANK_EN defined:
  - Digit i>0 outputs seg=0 when it and every higher digit are zero.
  - an stays asserted for that digit.
  - Digit 0 is never blanked.
- Not defined: every digit is decoded, so leading zeros display 1111110.

## Structure
- Package ssd_pkg:
  - opcode constants OP_ADD=0, OP_OR=1, OP_SUB=2, OP_XOR=3.
  - 16-entry seven-segment constant table.
- Sub-module hex_to_seg7: combinational 4-bit to 7-bit decoder using the package table, instantiated once.
- Top-level module holds the ALU, registers, scan counter and output logic.

## Test plan
Default parameters: N=8, DIGITS=3. PRESCALE=2 for all scenarios.
- Reset: rst_n=0 for 3 cycles with load=1 → seg=0, an=0, frame_done=0; result_q=0 after release.
- Carry: A=0xFF, B=0x01, ADD, load → result 0x100. Scan gives an=001/seg=1111110, an=010/seg=1111110, an=100/seg=0110000. frame_done pulses once per 6 cycles.
- Borrow: A=0x05, B=0x07, SUB → result 0x1FE. Scan gives an=001/seg=1001111, an=010/seg=1000111, an=100/seg=0110000.
- Enable=0 while dig_q=2 → next edge seg=0, an=0. Enable=1 → an=001 first, with 2-cycle dwell.
- Macro check: A=0x0A, B=0x00, OR → digit 0 seg=1110111. Digits 1 and 2 give seg=0 with the macro defined, 1111110 without.
- Reset mid-scan at dig_q=1, plus simultaneous load/advance edge (XOR 0x0F^0x07=0x008) → outputs zero after reset. After release, the new value appears exactly one edge after the load edge.
